// File: rtl/rf_wb_pkg.sv
// Shared defaults, entry layout and pointer sizing for the register-file write buffer.
package rf_wb_pkg;

    localparam int DEF_ADDR_BITS = 7;
    localparam int DEF_DATA_BITS = 13;
    localparam int DEF_DEPTH     = 4;

    typedef struct packed {
        logic [DEF_ADDR_BITS-1:0] addr;
        logic [DEF_DATA_BITS-1:0] data;
    } entry_t;

    // Queue pointers carry one extra wrap bit above the slot index.
    function automatic int ptr_bits(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/rf_wb_if.sv
// Producer, register-file write port and bypass lookup signals of the write buffer.
interface rf_wb_if #(
    parameter int ADDR_BITS = rf_wb_pkg::DEF_ADDR_BITS,
    parameter int DATA_BITS = rf_wb_pkg::DEF_DATA_BITS,
    parameter int DEPTH     = rf_wb_pkg::DEF_DEPTH
) ();

    logic                                   in_valid;
    logic                                   in_ready;
    logic [ADDR_BITS-1:0]                   in_addr;
    logic [DATA_BITS-1:0]                   in_data;
    logic                                   drain_en;
    logic                                   rf_we;
    logic [ADDR_BITS-1:0]                   rf_waddr;
    logic [DATA_BITS-1:0]                   rf_wdata;
    logic [ADDR_BITS-1:0]                   lookup_addr;
    logic                                   lookup_hit;
    logic [DATA_BITS-1:0]                   lookup_data;
    logic [rf_wb_pkg::ptr_bits(DEPTH)-1:0]  count;

    modport slave (
        input  in_valid, in_addr, in_data, drain_en, lookup_addr,
        output in_ready, rf_we, rf_waddr, rf_wdata, lookup_hit, lookup_data, count
    );

    modport master (
        output in_valid, in_addr, in_data, drain_en, lookup_addr,
        input  in_ready, rf_we, rf_waddr, rf_wdata, lookup_hit, lookup_data, count
    );

endinterface

// File: rtl/rf_wb_match.sv
// Bypass lookup: compares every occupied slot against the read address and
// returns the data of the youngest match (age 0 = most recently pushed).
module rf_wb_match #(
    parameter int  ADDR_BITS = rf_wb_pkg::DEF_ADDR_BITS,
    parameter int  DATA_BITS = rf_wb_pkg::DEF_DATA_BITS,
    parameter int  DEPTH     = rf_wb_pkg::DEF_DEPTH,
    parameter type entry_t   = rf_wb_pkg::entry_t,
    localparam int IDX_BITS  = $clog2(DEPTH)
) (
    input  entry_t [DEPTH-1:0]                i_entries,
    input  logic   [DEPTH-1:0]                i_occupied,
    input  logic   [DEPTH-1:0][IDX_BITS-1:0]  i_age,
    input  logic   [ADDR_BITS-1:0]            i_lookup_addr,
    output logic                              o_hit,
    output logic   [DATA_BITS-1:0]            o_data
);

    logic [IDX_BITS-1:0] w_best_age;

    always_comb begin
        // NOTE: every output gets a value before the loop, so no path leaves it unassigned (no latch).
        o_hit      = 1'b0;
        o_data     = '0;
        w_best_age = '1;
        for (int k = 0; k < DEPTH; k++) begin
            if (i_occupied[k] && (i_entries[k].addr == i_lookup_addr) &&
                (!o_hit || (i_age[k] < w_best_age))) begin
                o_hit      = 1'b1;
                w_best_age = i_age[k];
                o_data     = i_entries[k].data;
            end
        end
    end

endmodule

// File: rtl/rf_write_buffer.sv
// In-order staging queue ahead of the register-file write port, with a
// combinational bypass lookup over all pending writes.
module rf_write_buffer
    import rf_wb_pkg::*;
#(
    parameter int ADDR_BITS = DEF_ADDR_BITS,
    parameter int DATA_BITS = DEF_DATA_BITS,
    parameter int DEPTH     = DEF_DEPTH
) (
    input  logic    clk,
    input  logic    rst_n,
    rf_wb_if.slave  bus
);

    localparam int PTR_BITS = ptr_bits(DEPTH);
    localparam int IDX_BITS = PTR_BITS - 1;

    typedef struct packed {
        logic [ADDR_BITS-1:0] addr;
        logic [DATA_BITS-1:0] data;
    } wb_entry_t;

    wb_entry_t [DEPTH-1:0]               r_mem;
    logic      [PTR_BITS-1:0]            r_wp;
    logic      [PTR_BITS-1:0]            r_rp;

    logic      [IDX_BITS-1:0]            w_wp_idx;
    logic      [IDX_BITS-1:0]            w_rp_idx;
    logic      [PTR_BITS-1:0]            w_count;
    logic                                w_empty;
    logic                                w_full;
    logic                                w_push;
    logic                                w_pop;
    logic      [DEPTH-1:0]               w_occupied;
    logic      [DEPTH-1:0][IDX_BITS-1:0] w_age;

    assign w_wp_idx = r_wp[IDX_BITS-1:0];
    assign w_rp_idx = r_rp[IDX_BITS-1:0];
    assign w_count  = r_wp - r_rp;
    assign w_empty  = (r_wp == r_rp);
    assign w_full   = (w_wp_idx == w_rp_idx) && (r_wp[PTR_BITS-1] != r_rp[PTR_BITS-1]);

    // A full queue still accepts when the head leaves in the same cycle.
    assign bus.in_ready = !w_full || bus.drain_en;
    assign w_push       = bus.in_valid && bus.in_ready;
    assign w_pop        = bus.drain_en && !w_empty;

    assign bus.rf_we    = w_pop;
    assign bus.rf_waddr = r_mem[w_rp_idx].addr;
    assign bus.rf_wdata = r_mem[w_rp_idx].data;
    assign bus.count    = w_count;

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + PTR_BITS'(1);
            if (w_pop)  r_rp <= r_rp + PTR_BITS'(1);
        end
    end

    // NOTE: storage has no reset; emptiness is defined by the pointers alone.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[w_wp_idx] <= '{addr: bus.in_addr, data: bus.in_data};
    end

    // Per-slot occupancy (offset from head below count) and age (distance behind wp).
    for (genvar k = 0; k < DEPTH; k++) begin : g_slot
        logic [IDX_BITS-1:0] w_offset;
        assign w_offset      = IDX_BITS'(k) - w_rp_idx;
        assign w_occupied[k] = ({1'b0, w_offset} < w_count);
        assign w_age[k]      = w_wp_idx - IDX_BITS'(k) - IDX_BITS'(1);
    end

    rf_wb_match #(
        .ADDR_BITS (ADDR_BITS),
        .DATA_BITS (DATA_BITS),
        .DEPTH     (DEPTH),
        .entry_t   (wb_entry_t)
    ) u_match (
        .i_entries     (r_mem),
        .i_occupied    (w_occupied),
        .i_age         (w_age),
        .i_lookup_addr (bus.lookup_addr),
        .o_hit         (bus.lookup_hit),
        .o_data        (bus.lookup_data)
    );

endmodule
